writeback_pipe: RTL and testbench
=================================

# writeback_pipe

Write-back stage of the pipelined Y86-64 processor: holds the W pipeline register, owns the 15-entry register file and is the writer that the decode stage reads from. Captures memory-stage results each clock, commits valE/valM to the register file one cycle later, exposes W-stage values for decode forwarding, and tracks the sticky processor status and retired-instruction count.

## Interface
- DATA_W, 64, register/datapath width
- CNT_W, 32, retired-instruction counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- M_icode  in  4  memory-stage icode
- m_Stat  in  4  memory-stage status (1000 AOK, 0100 HLT, 0010 ADR, 0001 INS)
- M_valE  in  DATA_W  ALU result
- m_valM  in  DATA_W  memory read data
- M_dstE, M_dstM  in  4 each  destination registers (0xF = none)
- W_stall  in  1  hold W register
- W_bubble  in  1  load nop bubble into W register
- d_srcA, d_srcB  in  4 each  decode read addresses
- rf_valA, rf_valB  out  DATA_W each  register file read data (0 when address 0xF)
- W_icode  out  4;  W_Stat  out  4;  W_valE, W_valM  out  DATA_W;  W_dstE, W_dstM  out  4  — W register contents, for forwarding
- Stat  out  4  sticky processor status
- running  out  1  high while state RUN
- retired  out  CNT_W  instructions retired

## Operation
- W register: on clk edge, if W_stall or state != RUN, hold; else if W_bubble, load bubble (icode 1, Stat AOK, dst 0xF/0xF, vals 0); else load M_icode, m_Stat, M_valE, m_valM, M_dstE, M_dstM. Stall dominates bubble.
- Register file write on clk edge, only when W_Stat = AOK and state = RUN: W_dstE != 0xF -> rf[W_dstE] <= W_valE; W_dstM != 0xF -> rf[W_dstM] <= W_valM. W_dstE = W_dstM (e.g. popq %rsp): valM wins.
- Reads combinational: rf_valA = rf[d_srcA], rf_valB = rf[d_srcB]; no internal bypass (same-cycle read returns pre-write value; decode forwards W_val* itself). Address 0xF reads 0.
- State machine on W_Stat at clk edge: RUN —HLT→ HALT; RUN —ADR/INS→ FAULT; HALT, FAULT terminal until reset. Stat = AOK in RUN, else the latched W_Stat that caused exit. running = (state == RUN).
- The halting/faulting instruction makes no register write.
- Retire: counter +1 on each edge in RUN where W register holds a non-bubble AOK instruction and is not stalled this cycle (counted once, on the edge it commits). Wraps modulo 2^CNT_W.

## Timing
- Reset (async assert, sync-release assumed by caller): rf all 0, W register = bubble, W_* outputs = bubble values, Stat = AOK (1000), running = 1, retired = 0. Reset mid-operation discards in-flight write.
- Latency: M-stage values visible on W_* 1 cycle after capture edge; rf updated at next edge (2 edges after capture); rf_val* reflect it combinationally thereafter.
- Stall held N cycles: W_* stable, write repeats same data (idempotent), retire counts only once.
- State exit at edge k: writes and capture frozen from edge k on; Stat/running change after edge k.

## Configuration
- WB_RETIRE_CNT_EN defined: retire counter implemented as above.
- Undefined: no counter logic; retired tied to 0.

## Test plan
- Reset, then irmovq: M_icode 3, m_Stat AOK, M_valE 2, M_dstE 3, M_dstM 0xF -> after edge 1 W_valE 2, W_dstE 3; after edge 2 d_srcA 3 gives rf_valA 2, retired 1.
- popq %rsp: M_dstE 4 valE 16, M_dstM 4 valM 40 -> rf[4] = 40 after commit.
- W_stall high 3 cycles with OPq (dstE 11, valE 7) in W -> W_* unchanged, rf[11] = 7, retired increments once; W_bubble with W_stall -> hold.
- mrmovq with m_Stat ADR, M_dstM 5, valM 99 -> rf[5] stays 0, Stat = 0010, running = 0, later AOK inputs ignored, retired unchanged.
- halt (icode 0, Stat HLT) -> Stat = 0100, running 0; rst_n pulse low mid-cycle -> immediate Stat 1000, rf cleared, retired 0.
- Build without WB_RETIRE_CNT_EN -> retired 0 throughout, all other results identical.

Source files
------------

// File: rtl/writeback_pipe_if.sv
// -----------------------------------------------------------------------------
// writeback_pipe_if
//
// Bundles the memory-stage inputs, pipeline control, decode read port and the
// W-stage / status outputs of the Y86-64 write-back stage.
//
//   master : the surrounding pipeline (drives M_*, m_*, W_stall, W_bubble,
//            d_srcA, d_srcB; observes everything else)
//   slave  : writeback_pipe itself
//
// Signals
//   M_icode, m_Stat, M_valE, m_valM, M_dstE, M_dstM : memory-stage results
//   W_stall, W_bubble                               : W register control
//   d_srcA, d_srcB / rf_valA, rf_valB               : decode read port
//   W_icode, W_Stat, W_valE, W_valM, W_dstE, W_dstM : W register contents
//   Stat, running, retired                          : processor status
// -----------------------------------------------------------------------------
interface writeback_pipe_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
);
    logic [3:0]        M_icode;
    logic [3:0]        m_Stat;
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] m_valM;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;
    logic              W_stall;
    logic              W_bubble;
    logic [3:0]        d_srcA;
    logic [3:0]        d_srcB;
    logic [DATA_W-1:0] rf_valA;
    logic [DATA_W-1:0] rf_valB;
    logic [3:0]        W_icode;
    logic [3:0]        W_Stat;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;
    logic [3:0]        Stat;
    logic              running;
    logic [CNT_W-1:0]  retired;

    modport master (
        output M_icode, m_Stat, M_valE, m_valM, M_dstE, M_dstM,
        output W_stall, W_bubble, d_srcA, d_srcB,
        input  rf_valA, rf_valB,
        input  W_icode, W_Stat, W_valE, W_valM, W_dstE, W_dstM,
        input  Stat, running, retired
    );

    modport slave (
        input  M_icode, m_Stat, M_valE, m_valM, M_dstE, M_dstM,
        input  W_stall, W_bubble, d_srcA, d_srcB,
        output rf_valA, rf_valB,
        output W_icode, W_Stat, W_valE, W_valM, W_dstE, W_dstM,
        output Stat, running, retired
    );
endinterface

// File: rtl/writeback_pipe.sv
// -----------------------------------------------------------------------------
// writeback_pipe
//
// Write-back stage of the pipelined Y86-64 processor. Holds the W pipeline
// register, owns the 15-entry register file (%rax..%r14) read by decode,
// commits valE/valM one edge after capture, and tracks the sticky processor
// status plus the retired-instruction count.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   wb           : writeback_pipe_if.slave (all datapath / status signals)
//   dbg_state_o  : current run/halt/fault state, for observation only
//
// Build option
//   WB_RETIRE_CNT_EN : when defined, the retired-instruction counter is built;
//                      otherwise wb.retired is tied to zero.
//
// Flow control: there is no valid/ready pair. Every edge in RUN the W register
// either captures the memory stage, loads a bubble (W_bubble) or holds
// (W_stall, which dominates W_bubble). Once the processor leaves RUN the W
// register, register file and counter are frozen until reset.
// -----------------------------------------------------------------------------
module writeback_pipe #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_pipe_if.slave  wb,
    output logic [1:0]       dbg_state_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [3:0] STAT_AOK  = 4'b1000;
    localparam logic [3:0] STAT_HLT  = 4'b0100;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    // W pipeline register
    logic [3:0]        w_icode_q, w_icode_d;
    logic [3:0]        w_stat_q,  w_stat_d;
    logic [DATA_W-1:0] w_vale_q,  w_vale_d;
    logic [DATA_W-1:0] w_valm_q,  w_valm_d;
    logic [3:0]        w_dste_q,  w_dste_d;
    logic [3:0]        w_dstm_q,  w_dstm_d;

    // Processor state
    logic [1:0]        state_q, state_d;
    logic [3:0]        stat_q,  stat_d;

    logic [DATA_W-1:0] rf_q [0:14];

    logic run;
    logic commit_ok;
    logic capture_en;

    assign run = (state_q == ST_RUN);
    // A W entry with non-AOK status is the one taking us out of RUN: it must
    // neither write nor let the W register advance on the exit edge.
    assign commit_ok  = run && (w_stat_q == STAT_AOK);
    assign capture_en = commit_ok && !wb.W_stall;

    always_comb begin
        w_icode_d = w_icode_q;
        w_stat_d  = w_stat_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        if (capture_en) begin
            if (wb.W_bubble) begin
                w_icode_d = ICODE_NOP;
                w_stat_d  = STAT_AOK;
                w_vale_d  = '0;
                w_valm_d  = '0;
                w_dste_d  = REG_NONE;
                w_dstm_d  = REG_NONE;
            end else begin
                w_icode_d = wb.M_icode;
                w_stat_d  = wb.m_Stat;
                w_vale_d  = wb.M_valE;
                w_valm_d  = wb.m_valM;
                w_dste_d  = wb.M_dstE;
                w_dstm_d  = wb.M_dstM;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        if (run && (w_stat_q != STAT_AOK)) begin
            stat_d  = w_stat_q;
            state_d = (w_stat_q == STAT_HLT) ? ST_HALT : ST_FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_icode_q <= ICODE_NOP;
            w_stat_q  <= STAT_AOK;
            w_vale_q  <= '0;
            w_valm_q  <= '0;
            w_dste_q  <= REG_NONE;
            w_dstm_q  <= REG_NONE;
            state_q   <= ST_RUN;
            stat_q    <= STAT_AOK;
        end else begin
            w_icode_q <= w_icode_d;
            w_stat_q  <= w_stat_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
            state_q   <= state_d;
            stat_q    <= stat_d;
        end
    end

    // Register file. The valM write is issued after valE so that when both
    // destinations match (popq %rsp) the loaded value wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                rf_q[i] <= '0;
            end
        end else if (commit_ok) begin
            if (w_dste_q != REG_NONE) begin
                rf_q[w_dste_q] <= w_vale_q;
            end
            if (w_dstm_q != REG_NONE) begin
                rf_q[w_dstm_q] <= w_valm_q;
            end
        end
    end

    // No bypass: decode forwards from W_val* itself.
    assign wb.rf_valA = (wb.d_srcA == REG_NONE) ? '0 : rf_q[wb.d_srcA];
    assign wb.rf_valB = (wb.d_srcB == REG_NONE) ? '0 : rf_q[wb.d_srcB];

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_ev;

    // Bubbles (icode nop) are not instructions. A stalled entry is counted on
    // the edge it finally leaves W, so a long stall counts once.
    assign retire_ev = capture_en && (w_icode_q != ICODE_NOP);

    always_comb begin
        retired_d = retired_q;
        if (retire_ev) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign wb.retired = retired_q;
`else
    assign wb.retired = '0;
`endif

    assign wb.W_icode = w_icode_q;
    assign wb.W_Stat  = w_stat_q;
    assign wb.W_valE  = w_vale_q;
    assign wb.W_valM  = w_valm_q;
    assign wb.W_dstE  = w_dste_q;
    assign wb.W_dstM  = w_dstm_q;
    assign wb.Stat    = stat_q;
    assign wb.running = run;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_writeback_pipe.sv
// -----------------------------------------------------------------------------
// tb_writeback_pipe
//
// Self-checking bench for writeback_pipe: a directed vector table from reset
// (irmovq, popq %rsp, stalled OPq, bubble, faulting mrmovq), hand-written halt
// and mid-cycle reset sequences, then randomized traffic checked against a
// cycle-level reference model of the write-back rules.
// -----------------------------------------------------------------------------
module tb_writeback_pipe;

    localparam int DW = 64;
    localparam int CW = 32;

    localparam logic [3:0] AOK   = 4'b1000;
    localparam logic [3:0] HLT   = 4'b0100;
    localparam logic [3:0] ADR   = 4'b0010;
    localparam logic [3:0] INS   = 4'b0001;
    localparam logic [3:0] RNONE = 4'hF;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    writeback_pipe_if #(.DATA_W(DW), .CNT_W(CW)) wb();

    writeback_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wb),
        .dbg_state_o (dbg_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  stat;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [63:0] vale;
        logic [63:0] valm;
    } wreg_t;

    wreg_t       m_w;
    logic [63:0] m_rf [16];
    logic        m_done;
    logic [3:0]  m_stat;
    logic [31:0] m_ret;

    function automatic wreg_t bubble_w();
        wreg_t b;
        b.icode = 4'h1; b.stat = AOK; b.dste = RNONE; b.dstm = RNONE;
        b.vale = '0; b.valm = '0;
        return b;
    endfunction

    task automatic model_reset();
        m_w = bubble_w();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_done = 1'b0;
        m_stat = AOK;
        m_ret  = '0;
    endtask

    // One clock edge: the instruction in W commits (if good), then W advances.
    task automatic model_edge(input logic stall, input logic bubble, input wreg_t in);
        if (!m_done) begin
            if (m_w.stat == AOK) begin
                if (m_w.dste != RNONE) m_rf[m_w.dste] = m_w.vale;
                if (m_w.dstm != RNONE) m_rf[m_w.dstm] = m_w.valm;
                if (!stall) begin
                    if (m_w.icode != 4'h1) m_ret = m_ret + 1;
                    m_w = bubble ? bubble_w() : in;
                end
            end else begin
                m_done = 1'b1;
                m_stat = m_w.stat;
            end
        end
    endtask

    function automatic logic [63:0] m_read(input logic [3:0] a);
        return (a == RNONE) ? 64'd0 : m_rf[a];
    endfunction

    function automatic logic [31:0] ret_exp(input logic [31:0] v);
`ifdef WB_RETIRE_CNT_EN
        return v;
`else
        return (v == v) ? 32'd0 : 32'd0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input wreg_t in, input logic stall, input logic bubble,
                         input logic [3:0] sa, input logic [3:0] sb);
        wb.M_icode  = in.icode;
        wb.m_Stat   = in.stat;
        wb.M_valE   = in.vale;
        wb.m_valM   = in.valm;
        wb.M_dstE   = in.dste;
        wb.M_dstM   = in.dstm;
        wb.W_stall  = stall;
        wb.W_bubble = bubble;
        wb.d_srcA   = sa;
        wb.d_srcB   = sb;
    endtask

    task automatic do_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(bubble_w(), 1'b0, 1'b0, RNONE, RNONE);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " W_icode"}, 64'(wb.W_icode), 64'h1);
        check({tag, " W_Stat"},  64'(wb.W_Stat),  64'(AOK));
        check({tag, " W_valE"},  wb.W_valE,       64'd0);
        check({tag, " W_dstE"},  64'(wb.W_dstE),  64'(RNONE));
        check({tag, " W_dstM"},  64'(wb.W_dstM),  64'(RNONE));
        check({tag, " Stat"},    64'(wb.Stat),    64'(AOK));
        check({tag, " running"}, 64'(wb.running), 64'd1);
        check({tag, " retired"}, 64'(wb.retired), 64'd0);
    endtask

    function automatic wreg_t mk(input logic [3:0] ic, input logic [3:0] st,
                                 input logic [63:0] ve, input logic [63:0] vm,
                                 input logic [3:0] de, input logic [3:0] dm);
        wreg_t w;
        w.icode = ic; w.stat = st; w.vale = ve; w.valm = vm; w.dste = de; w.dstm = dm;
        return w;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  stat;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic        stall;
        logic        bubble;
        logic [3:0]  srca;
        logic [3:0]  srcb;
        logic [63:0] e_vale;
        logic [3:0]  e_dste;
        logic [63:0] e_rfa;
        logic [63:0] e_rfb;
        logic [3:0]  e_stat;
        logic        e_run;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vecs [10];

    initial begin
        wreg_t in;
        logic  st, bb;
        logic [3:0] sa, sb;
        int    idle;

        //           icode stat  valE valM dstE   dstM   stl bub sA     sB     | valE dstE   rfA rfB Stat run ret
        vecs[0] = '{4'h3, AOK,  2,   0,   4'd3,  RNONE, 0,  0,  4'd3,  RNONE, 2,   4'd3,  0,  0,  AOK, 1,  0};
        vecs[1] = '{4'hB, AOK,  16,  40,  4'd4,  4'd4,  0,  0,  4'd3,  4'd4,  16,  4'd4,  2,  0,  AOK, 1,  1};
        vecs[2] = '{4'h6, AOK,  7,   0,   4'd11, RNONE, 0,  0,  4'd4,  4'd3,  7,   4'd11, 40, 2,  AOK, 1,  2};
        vecs[3] = '{4'h3, AOK,  55,  0,   4'd2,  RNONE, 1,  0,  4'd11, 4'd2,  7,   4'd11, 7,  0,  AOK, 1,  2};
        vecs[4] = '{4'h3, AOK,  55,  0,   4'd2,  RNONE, 1,  1,  4'd11, RNONE, 7,   4'd11, 7,  0,  AOK, 1,  2};
        vecs[5] = '{4'h3, AOK,  55,  0,   4'd2,  RNONE, 1,  0,  4'd11, 4'd4,  7,   4'd11, 7,  40, AOK, 1,  2};
        vecs[6] = '{4'h3, AOK,  55,  0,   4'd2,  RNONE, 0,  1,  4'd2,  4'd11, 0,   RNONE, 0,  7,  AOK, 1,  3};
        vecs[7] = '{4'h5, ADR,  0,   99,  RNONE, 4'd5,  0,  0,  4'd5,  4'd3,  0,   RNONE, 0,  2,  AOK, 1,  3};
        vecs[8] = '{4'h3, AOK,  77,  0,   4'd5,  RNONE, 0,  0,  4'd5,  RNONE, 0,   RNONE, 0,  0,  ADR, 0,  3};
        vecs[9] = '{4'h3, AOK,  77,  0,   4'd5,  RNONE, 0,  0,  4'd5,  4'd11, 0,   RNONE, 0,  7,  ADR, 0,  3};

        // ---- reset state ----
        apply_reset();
        wb.d_srcA = 4'd3;
        #1;
        check_reset_state("reset");
        check("reset rf_valA", wb.rf_valA, 64'd0);

        // ---- table ----
        for (int i = 0; i < 10; i++) begin
            drive(mk(vecs[i].icode, vecs[i].stat, vecs[i].vale, vecs[i].valm,
                     vecs[i].dste, vecs[i].dstm),
                  vecs[i].stall, vecs[i].bubble, vecs[i].srca, vecs[i].srcb);
            do_edge();
            check($sformatf("vec%0d W_valE", i),  wb.W_valE,           vecs[i].e_vale);
            check($sformatf("vec%0d W_dstE", i),  64'(wb.W_dstE),      64'(vecs[i].e_dste));
            check($sformatf("vec%0d rf_valA", i), wb.rf_valA,          vecs[i].e_rfa);
            check($sformatf("vec%0d rf_valB", i), wb.rf_valB,          vecs[i].e_rfb);
            check($sformatf("vec%0d Stat", i),    64'(wb.Stat),        64'(vecs[i].e_stat));
            check($sformatf("vec%0d running", i), 64'(wb.running),     64'(vecs[i].e_run));
            check($sformatf("vec%0d retired", i), 64'(wb.retired),     64'(ret_exp(vecs[i].e_ret)));
        end
        check("fault W_dstM held", 64'(wb.W_dstM), 64'd5);

        // ---- halt sequence, then mid-cycle reset ----
        apply_reset();
        drive(mk(4'h3, AOK, 64'd9, 64'd0, 4'd6, RNONE), 1'b0, 1'b0, 4'd6, RNONE);
        do_edge();
        drive(mk(4'h0, HLT, 64'd0, 64'd0, RNONE, RNONE), 1'b0, 1'b0, 4'd6, RNONE);
        do_edge();
        check("halt rf6 committed", wb.rf_valA, 64'd9);
        drive(mk(4'h3, AOK, 64'd5, 64'd0, 4'd6, RNONE), 1'b0, 1'b0, 4'd6, RNONE);
        #1;
        check("halt W_Stat", 64'(wb.W_Stat), 64'(HLT));
        check("halt pre-exit running", 64'(wb.running), 64'd1);
        do_edge();
        check("halt Stat", 64'(wb.Stat), 64'(HLT));
        check("halt running", 64'(wb.running), 64'd0);
        check("halt retired", 64'(wb.retired), 64'(ret_exp(32'd1)));
        do_edge();
        check("halt rf6 frozen", wb.rf_valA, 64'd9);
        check("halt W_icode frozen", 64'(wb.W_icode), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        check("midrst rf6 cleared", wb.rf_valA, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // ---- randomized traffic against the model ----
        idle = 0;
        for (int c = 0; c < 500; c++) begin
            int r;
            r = $urandom_range(0, 99);
            in.icode = 4'($urandom_range(0, 15));
            in.stat  = (r < 96) ? AOK : (r < 97) ? HLT : (r < 98) ? ADR : INS;
            in.vale  = {$urandom, $urandom};
            in.valm  = {$urandom, $urandom};
            in.dste  = 4'($urandom_range(0, 15));
            in.dstm  = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 99) < 20);
            bb = ($urandom_range(0, 99) < 15);
            sa = 4'($urandom_range(0, 15));
            sb = 4'($urandom_range(0, 15));
            drive(in, st, bb, sa, sb);
            model_edge(st, bb, in);
            do_edge();
            exp_q.push_back(m_read(sa));
            exp_q.push_back(m_read(sb));
            check("rnd W_icode", 64'(wb.W_icode), 64'(m_w.icode));
            check("rnd W_Stat",  64'(wb.W_Stat),  64'(m_w.stat));
            check("rnd W_valE",  wb.W_valE,       m_w.vale);
            check("rnd W_valM",  wb.W_valM,       m_w.valm);
            check("rnd W_dstE",  64'(wb.W_dstE),  64'(m_w.dste));
            check("rnd W_dstM",  64'(wb.W_dstM),  64'(m_w.dstm));
            check("rnd Stat",    64'(wb.Stat),    64'(m_stat));
            check("rnd running", 64'(wb.running), 64'(!m_done));
            check("rnd retired", 64'(wb.retired), 64'(ret_exp(m_ret)));
            check("rnd rf_valA", wb.rf_valA, exp_q.pop_front());
            check("rnd rf_valB", wb.rf_valB, exp_q.pop_front());
            if (m_done) begin
                idle++;
                if (idle > 3) begin
                    apply_reset();
                    idle = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
